// File: rtl/dmem_dump_pkg.sv
// Shared definitions for the data memory with clear sweep and dump port.
package dmem_dump_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W register array: one synchronous write port, two asynchronous read ports.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; reads below see the pre-edge contents (read-before-write)
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/dmem_dump.sv
// Data memory with post-reset clear sweep, registered core read port and
// a valid/ready dump stream that runs alongside core accesses.
module dmem_dump
    import dmem_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              Ready,
    input  logic              DumpStart,
    input  logic [ADDR_W-1:0] DumpFirst,
    input  logic [ADDR_W-1:0] DumpLast,
    output logic              DumpBusy,
    output logic [DATA_W-1:0] PrintOut,
    output logic              PrintValid,
    input  logic              PrintReady,
    output logic              PrintLast
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              ready_r;
    logic [ADDR_W-1:0] dump_ptr_r;
    logic [ADDR_W-1:0] dump_last_r;
    logic              busy_r;
    logic [DATA_W-1:0] print_out_r;
    logic              print_valid_r;
    logic              print_last_r;
    logic [DATA_W-1:0] data_out_r;
    logic              data_valid_r;

    logic              core_wr_s;
    logic              core_rd_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] core_rdata_s;
    logic [DATA_W-1:0] dump_rdata_s;

    // Write-port arbitration: the clear sweep owns the port until Ready
    always_comb begin
        core_wr_s = ready_r & E & WE;
        core_rd_s = ready_r & E & ~WE;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_ptr_r;
            mem_wdata_s = {DATA_W{1'b0}};
        end else begin
            mem_we_s    = core_wr_s;
            mem_waddr_s = Addr;
            mem_wdata_s = DataIn;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_s),
        .waddr   (mem_waddr_s),
        .wdata   (mem_wdata_s),
        .raddr_a (Addr),
        .raddr_b (dump_ptr_r),
        .rdata_a (core_rdata_s),
        .rdata_b (dump_rdata_s)
    );

    // Core read register: DataOut holds between reads, DataValid is a one-cycle flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r   <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
        end else if (core_rd_s) begin
            data_out_r   <= core_rdata_s;
            data_valid_r <= 1'b1;
        end else begin
            data_valid_r <= 1'b0;
        end
    end

    // Clear sweep and dump FSM with registered stream outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_CLEAR;
            clr_ptr_r     <= {ADDR_W{1'b0}};
            ready_r       <= 1'b0;
            dump_ptr_r    <= {ADDR_W{1'b0}};
            dump_last_r   <= {ADDR_W{1'b0}};
            busy_r        <= 1'b0;
            print_out_r   <= {DATA_W{1'b0}};
            print_valid_r <= 1'b0;
            print_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + ADDR_ONE;
                    if (&clr_ptr_r) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (DumpStart) begin
                        dump_ptr_r  <= DumpFirst;
                        dump_last_r <= DumpLast;
                        busy_r      <= 1'b1;
                        state_r     <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (print_valid_r & PrintReady & print_last_r) begin
                        print_valid_r <= 1'b0;
                        print_last_r  <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else if (!print_valid_r | PrintReady) begin
                        // Pointer wraps naturally modulo DEPTH
                        print_out_r   <= dump_rdata_s;
                        print_valid_r <= 1'b1;
                        print_last_r  <= (dump_ptr_r == dump_last_r);
                        dump_ptr_r    <= dump_ptr_r + ADDR_ONE;
                    end
                end
                default: begin
                    state_r       <= ST_CLEAR;
                    clr_ptr_r     <= {ADDR_W{1'b0}};
                    ready_r       <= 1'b0;
                    busy_r        <= 1'b0;
                    print_valid_r <= 1'b0;
                    print_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign DataOut    = data_out_r;
    assign DataValid  = data_valid_r;
    assign Ready      = ready_r;
    assign DumpBusy   = busy_r;
    assign PrintOut   = print_out_r;
    assign PrintValid = print_valid_r;
    assign PrintLast  = print_last_r;

endmodule
